sms_line_receiver: RTL and testbench

Clocked receiver for wired, pulled-up SMS signal lines driven by open-collector drivers, which either drive a line or leave it floating. Each line is resolved with pull-up semantics, synchronized and glitch-filtered. The block emits a one-cycle strobe when a line is asserted (pulled low) or released. It flags lines held asserted too long and counts assertion events. It sits between asynchronous card-level wired nets and the clocked simulation or verification fabric.

---
 rtl/sms_line_receiver.sv | 156 +++++++++++++++
 tb/tb_sms_line_receiver.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sms_line_receiver.sv
// sms_line_receiver
//
// Receives open-collector, pulled-up signal lines from card-level wiring.
// Each line is resolved with pull-up semantics, synchronized, glitch
// filtered, and reported to the clocked fabric as a clean level. The block
// also strobes on every accepted edge, flags lines held asserted (low) for
// too long, and keeps a saturating count of assertion events.
//
// Ports:
//   i_clk           rising-edge clock
//   i_reset         asynchronous, active-high reset
//   i_line          wired lines (each bit may be 1, 0, z or x)
//   i_clr_count     synchronous clear of o_count (wins over same-cycle events)
//   o_level         filtered resolved level per line, 1 = released
//   o_assert_pulse  one-cycle strobe per accepted 1->0 change
//   o_release_pulse one-cycle strobe per accepted 0->1 change
//   o_stuck         line filtered-asserted for STUCK or more cycles
//   o_count         saturating total of assertion events over all lines
module sms_line_receiver #(
    parameter int WIDTH  = 4,
    parameter int FILTER = 3,
    parameter int STUCK  = 255,
    parameter int CNT_W  = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_line,
    input  logic             i_clr_count,
    output logic [WIDTH-1:0] o_level,
    output logic [WIDTH-1:0] o_assert_pulse,
    output logic [WIDTH-1:0] o_release_pulse,
    output logic [WIDTH-1:0] o_stuck,
    output logic [CNT_W-1:0] o_count
);

    localparam int FC_W  = $clog2(FILTER) + 1;
    localparam int SC_W  = $clog2(STUCK + 1);
    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int SUM_W = CNT_W + PC_W;

    localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FILTER - 1);
    localparam logic [SC_W-1:0]  SC_MAX  = SC_W'(STUCK);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] w_resolved;
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_assert_pulse;
    logic [WIDTH-1:0] w_release_pulse;
    logic [WIDTH-1:0] w_stuck;
    logic [CNT_W-1:0] r_count;
    logic [PC_W-1:0]  w_pop;
    logic [SUM_W-1:0] w_sum;

    // Two-flop synchronizer; resets to the released (pulled-up) level.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_s1 <= '1;
            r_s2 <= '1;
        end else begin
            r_s1 <= w_resolved;
            r_s2 <= r_s1;
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [FC_W-1:0] r_fc;
            logic [SC_W-1:0] r_sc;
            logic            r_level;
            logic            r_assert_pulse;
            logic            r_release_pulse;
            logic            w_mismatch;
            logic            w_accept;

            // Pull-up model: only a driven 0 or an undetermined value counts
            // as asserted; a floating line reads as released.
            assign w_resolved[gi] = (i_line[gi] !== 1'b0) && (i_line[gi] !== 1'bx);

            assign w_mismatch = (r_s2[gi] != r_level);
            // The current mismatch is the FILTER-th in a row.
            assign w_accept   = w_mismatch && (r_fc == FC_LAST);
            assign w_fall[gi] = w_accept && !r_s2[gi];
            assign w_rise[gi] = w_accept &&  r_s2[gi];

            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_fc            <= '0;
                    r_sc            <= '0;
                    r_level         <= 1'b1;
                    r_assert_pulse  <= 1'b0;
                    r_release_pulse <= 1'b0;
                end else begin
                    r_assert_pulse  <= w_fall[gi];
                    r_release_pulse <= w_rise[gi];

                    if (!w_mismatch || w_accept) begin
                        r_fc <= '0;
                    end else begin
                        r_fc <= r_fc + 1'b1;
                    end

                    if (w_accept) begin
                        r_level <= r_s2[gi];
                    end

                    // Clearing on the accepted release (not one cycle later)
                    // drops stuck on the same edge the release strobe rises.
                    if (r_level || w_rise[gi]) begin
                        r_sc <= '0;
                    end else if (r_sc != SC_MAX) begin
                        r_sc <= r_sc + 1'b1;
                    end
                end
            end

            assign w_level[gi]         = r_level;
            assign w_assert_pulse[gi]  = r_assert_pulse;
            assign w_release_pulse[gi] = r_release_pulse;
            assign w_stuck[gi]         = (r_sc == SC_MAX);
        end
    endgenerate

    // Number of assertion strobes being launched this cycle.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + PC_W'(w_fall[i]);
        end
    end

    // Widened so the saturation test cannot be fooled by a wrap.
    assign w_sum = SUM_W'(r_count) + SUM_W'(w_pop);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clr_count) begin
            r_count <= '0;
        end else if (w_sum > SUM_W'(CNT_MAX)) begin
            r_count <= CNT_MAX;
        end else begin
            r_count <= w_sum[CNT_W-1:0];
        end
    end

    assign o_level         = w_level;
    assign o_assert_pulse  = w_assert_pulse;
    assign o_release_pulse = w_release_pulse;
    assign o_stuck         = w_stuck;
    assign o_count         = r_count;

endmodule

// File: tb/tb_sms_line_receiver.sv
// Testbench for sms_line_receiver (WIDTH=4, FILTER=3, STUCK=8, CNT_W=2).
// The model resolves each line from what the bench intends to drive, keeps
// the last FILTER+1 resolved samples per line and accepts a change when the
// FILTER synchronized samples seen by the filter all differ from the level.
module tb_sms_line_receiver;
    localparam int WIDTH   = 4;
    localparam int FILTER  = 3;
    localparam int STUCK   = 8;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic [WIDTH-1:0] drv_z   = 4'hF;  // 1 = line left floating
    logic [WIDTH-1:0] drv_val = 4'h0;  // driven value when not floating

    wire [WIDTH-1:0] line_w;
    wire [WIDTH-1:0] level;
    wire [WIDTH-1:0] ap;
    wire [WIDTH-1:0] rp;
    wire [WIDTH-1:0] stuck;
    wire [CNT_W-1:0] count;

    int n_vec = 0;
    int n_bad = 0;

    // Card-level wired nets with pull-ups.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_net
        wire lb;
        pullup (lb);
        assign lb = drv_z[gi] ? 1'bz : drv_val[gi];
        assign line_w[gi] = lb;
    end

    sms_line_receiver #(
        .WIDTH (WIDTH),
        .FILTER(FILTER),
        .STUCK (STUCK),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_line         (line_w),
        .i_clr_count    (clr),
        .o_level        (level),
        .o_assert_pulse (ap),
        .o_release_pulse(rp),
        .o_stuck        (stuck),
        .o_count        (count)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    logic [FILTER:0]  m_hist [WIDTH];  // [0] newest resolved sample
    logic [WIDTH-1:0] m_level;
    logic [WIDTH-1:0] m_ap;
    logic [WIDTH-1:0] m_rp;
    int               m_low [WIDTH];   // edges spent low since the fall
    int               m_count;

    function automatic logic resolved(input int i);
        return drv_z[i] ? 1'b1 : (drv_val[i] === 1'b1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < WIDTH; i++) begin
            m_hist[i] = '1;
            m_low[i]  = 0;
        end
        m_level = '1;
        m_ap    = '0;
        m_rp    = '0;
        m_count = 0;
    endtask

    task automatic model_step();
        int pops;
        logic all_diff;
        pops = 0;
        for (int i = 0; i < WIDTH; i++) begin
            m_ap[i] = 1'b0;
            m_rp[i] = 1'b0;
            all_diff = 1'b1;
            for (int k = 1; k <= FILTER; k++) begin
                if (m_hist[i][k] == m_level[i]) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_level[i] = ~m_level[i];
                if (!m_level[i]) begin
                    m_ap[i]  = 1'b1;
                    m_low[i] = 0;
                    pops++;
                end else begin
                    m_rp[i] = 1'b1;
                end
            end else if (!m_level[i]) begin
                m_low[i]++;
            end
            m_hist[i] = {m_hist[i][FILTER-1:0], resolved(i)};
        end
        if (clr) m_count = 0;
        else m_count = (m_count + pops > CNT_MAX) ? CNT_MAX : m_count + pops;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [WIDTH-1:0] es;
        for (int i = 0; i < WIDTH; i++) es[i] = !m_level[i] && (m_low[i] >= STUCK);
        chk("level", 32'(level), 32'(m_level));
        chk("assert_pulse", 32'(ap), 32'(m_ap));
        chk("release_pulse", 32'(rp), 32'(m_rp));
        chk("stuck", 32'(stuck), 32'(es));
        chk("count", 32'(count), 32'(m_count));
    endtask

    // Compare process: advance the model on each edge, check 1 unit later.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) model_reset();
            else model_step();
            #1;
            check_all();
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        tick(3);
        rst = 1'b0;

        // Idle lines floating, then driven high.
        tick(20);
        chk("idle_z_level", 32'(level), 32'hF);
        chk("idle_z_count", 32'(count), 32'h0);
        chk("idle_z_pulses", 32'({ap, rp}), 32'h0);
        drv_z = 4'h0; drv_val = 4'hF;
        tick(20);
        chk("idle_1_level", 32'(level), 32'hF);
        chk("idle_1_pulses", 32'({ap, rp}), 32'h0);
        drv_z = 4'hF;

        // Assert line 0: strobe on the 4th edge after the first sampling edge.
        drv_z[0] = 1'b0; drv_val[0] = 1'b0;
        tick(4);
        chk("a0_early", 32'(ap), 32'h0);
        tick(1);
        chk("a0_pulse", 32'(ap), 32'h1);
        chk("a0_level", 32'(level), 32'hE);
        chk("a0_count", 32'(count), 32'h1);
        tick(1);
        chk("a0_once", 32'(ap), 32'h0);
        tick(10);
        drv_z[0] = 1'b1;
        tick(4);
        chk("r0_early", 32'(rp), 32'h0);
        tick(1);
        chk("r0_pulse", 32'(rp), 32'h1);
        chk("r0_level", 32'(level), 32'hF);

        // Two-cycle glitch on line 1 is rejected.
        tick(3);
        drv_z[1] = 1'b0; drv_val[1] = 1'b0;
        tick(2);
        drv_z[1] = 1'b1;
        tick(10);
        chk("glitch_level", 32'(level), 32'hF);
        chk("glitch_count", 32'(count), 32'h1);

        // Stuck on line 2.
        drv_z[2] = 1'b0; drv_val[2] = 1'b0;
        tick(5);
        chk("s2_fall", 32'(ap), 32'h4);
        tick(7);
        chk("s2_not_yet", 32'(stuck), 32'h0);
        tick(1);
        chk("s2_stuck", 32'(stuck), 32'h4);
        tick(3);
        drv_z[2] = 1'b1;
        tick(4);
        chk("s2_hold", 32'(stuck), 32'h4);
        tick(1);
        chk("s2_rel_pulse", 32'(rp), 32'h4);
        chk("s2_rel_stuck", 32'(stuck), 32'h0);

        // Clear, then three simultaneous assertions and saturation.
        tick(3);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr_count", 32'(count), 32'h0);
        drv_z[2:0] = 3'b000; drv_val[2:0] = 3'b000;
        tick(5);
        chk("tri_pulse", 32'(ap), 32'h7);
        chk("tri_count", 32'(count), 32'h3);
        drv_z[2:0] = 3'b111;
        tick(8);
        drv_z[3] = 1'b0; drv_val[3] = 1'bx;
        tick(5);
        chk("x3_pulse", 32'(ap), 32'h8);
        chk("x3_level", 32'(level), 32'h7);
        chk("sat_count", 32'(count), 32'h3);
        tick(5);
        drv_z[3] = 1'b1;
        tick(5);
        chk("x3_release", 32'(rp), 32'h8);

        // clr_count in the same cycle as an assertion wins.
        tick(3);
        drv_z[0] = 1'b0; drv_val[0] = 1'b0;
        tick(4);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr_ev_pulse", 32'(ap), 32'h1);
        chk("clr_ev_count", 32'(count), 32'h0);
        tick(1);
        chk("clr_ev_after", 32'(count), 32'h0);
        drv_z[0] = 1'b1;
        tick(8);

        // Reset mid-stuck-count and mid-filter.
        drv_z[2] = 1'b0; drv_val[2] = 1'b0;
        tick(14);
        drv_z[1] = 1'b0; drv_val[1] = 1'b0;
        tick(3);
        chk("pre_rst_level", 32'(level), 32'hB);
        chk("pre_rst_stuck", 32'(stuck), 32'h4);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_level", 32'(level), 32'hF);
        chk("rst_pulses", 32'({ap, rp}), 32'h0);
        chk("rst_stuck", 32'(stuck), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        tick(1);
        rst = 1'b0;
        tick(4);
        chk("post_rst_early", 32'(ap), 32'h0);
        tick(1);
        chk("post_rst_pulse", 32'(ap), 32'h6);
        chk("post_rst_count", 32'(count), 32'h2);
        tick(10);
        drv_z = 4'hF;
        tick(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
